elevator_scheduler: RTL

- Cycle-level car controller for the FPGA elevator.
- Latches floor-call pulses into a pending bitmap and serves them with a LOOK policy: keep the current direction while calls remain ahead, otherwise reverse.
- Sequences car motion and door dwell from an internal 10 kHz tick strobe, so the fabric has no derived clock.
- Drives the floor display, door and direction outputs.

---
 rtl/elev_pkg.sv | 22 ++
 rtl/elev_tick_gen.sv | 28 ++
 rtl/elevator_scheduler.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/elev_pkg.sv
// Shared definitions for the elevator car controller: state encoding,
// default timing constants and a width helper.
package elev_pkg;

    localparam int ELEV_TICK_DIV   = 9999;
    localparam int ELEV_MOVE_TICKS = 20000;
    localparam int ELEV_DOOR_TICKS = 30000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MOVE = 2'd1;
    localparam logic [1:0] ST_DOOR = 2'd2;

    // Bits needed to hold 0..n-1, never less than 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/elev_tick_gen.sv
// Free-running strobe generator: tick is high for one clk100m cycle every
// TICK_DIV+1 cycles.
module elev_tick_gen
    import elev_pkg::*;
#(
    parameter int TICK_DIV = ELEV_TICK_DIV
) (
    input  logic clk100m,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = clog2(TICK_DIV + 1);

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CW'(TICK_DIV));

    always_ff @(posedge clk100m or negedge rst_n) begin
        if (!rst_n)      r_cnt <= '0;
        else if (w_wrap) r_cnt <= '0;
        else             r_cnt <= r_cnt + CW'(1);
    end

    assign tick = w_wrap;

endmodule

// File: rtl/elevator_scheduler.sv
// LOOK-policy elevator car controller with tick-paced motion and door dwell.
// Optional ELEV_DOOR_HOLD_EN adds a door_hold input that keeps the door open.
module elevator_scheduler
    import elev_pkg::*;
#(
    parameter int NUM_FLOORS = 8,
    parameter int TICK_DIV   = ELEV_TICK_DIV,
    parameter int MOVE_TICKS = ELEV_MOVE_TICKS,
    parameter int DOOR_TICKS = ELEV_DOOR_TICKS,
    localparam int FW        = clog2(NUM_FLOORS)
) (
    input  logic                  clk100m,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] req_pulse,
`ifdef ELEV_DOOR_HOLD_EN
    input  logic                  door_hold,
`endif
    output logic [FW-1:0]         cur_floor,
    output logic                  dir_up,
    output logic                  moving,
    output logic                  door_open,
    output logic                  arrive_pulse,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int MAXT = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
    localparam int SW   = clog2(MAXT);
    localparam logic [FW-1:0] TOP = FW'(NUM_FLOORS - 1);

    logic [1:0]            r_state;
    logic [SW-1:0]         r_step;
    logic [FW-1:0]         r_floor;
    logic                  r_dir;
    logic                  r_arrive;
    logic [NUM_FLOORS-1:0] r_pending;

    logic                  w_tick;
    logic                  w_hold;
    logic [NUM_FLOORS-1:0] w_pend_now;
    logic [NUM_FLOORS-1:0] w_above;
    logic [NUM_FLOORS-1:0] w_below;
    logic [NUM_FLOORS-1:0] w_onehot;
    logic [NUM_FLOORS-1:0] w_clr;
    logic                  w_idle_up;
    logic                  w_idle_dn;
    logic                  w_arr_here;
    logic                  w_arr_ahead;
    logic                  w_step_done;

    elev_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk100m (clk100m),
        .rst_n   (rst_n),
        .tick    (w_tick)
    );

`ifdef ELEV_DOOR_HOLD_EN
    assign w_hold = door_hold;
`else
    assign w_hold = 1'b0;
`endif

    always_comb begin
        w_above = '0;
        w_below = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            w_above[i] = (FW'(i) > r_floor);
            w_below[i] = (FW'(i) < r_floor);
        end
    end

    // Arrival decisions also see this cycle's pulses, so a call landing on
    // the arrive cycle still opens the door there.
    assign w_pend_now  = r_pending | req_pulse;
    assign w_onehot    = NUM_FLOORS'(1) << r_floor;
    assign w_idle_up   = |(r_pending & w_above);
    assign w_idle_dn   = |(r_pending & w_below);
    assign w_arr_here  = w_pend_now[r_floor];
    assign w_arr_ahead = r_dir ? |(w_pend_now & w_above) : |(w_pend_now & w_below);
    assign w_step_done = (r_state == ST_MOVE) && !r_arrive && w_tick &&
                         (r_step == SW'(MOVE_TICKS - 1));

    always_comb begin
        w_clr = '0;
        case (r_state)
            ST_IDLE: if (r_pending[r_floor])        w_clr = w_onehot;
            ST_MOVE: if (r_arrive && w_arr_here)    w_clr = w_onehot;
            ST_DOOR:                                w_clr = w_onehot;
            default: ;
        endcase
    end

    always_ff @(posedge clk100m or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_step    <= '0;
            r_floor   <= '0;
            r_dir     <= 1'b1;
            r_arrive  <= 1'b0;
            r_pending <= '0;
        end else begin
            r_pending <= w_pend_now & ~w_clr;
            r_arrive  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_step <= '0;
                    if (r_pending[r_floor]) begin
                        r_state <= ST_DOOR;
                    end else if (r_dir ? w_idle_up : w_idle_dn) begin
                        r_state <= ST_MOVE;
                    end else if (r_dir ? w_idle_dn : w_idle_up) begin
                        r_dir   <= ~r_dir;
                        r_state <= ST_MOVE;
                    end
                end
                ST_MOVE: begin
                    if (r_arrive) begin
                        r_step <= '0;
                        if (w_arr_here)        r_state <= ST_DOOR;
                        else if (!w_arr_ahead) r_state <= ST_IDLE;
                    end else if (w_tick) begin
                        if (w_step_done) begin
                            r_step   <= '0;
                            r_arrive <= 1'b1;
                            r_floor  <= r_dir ? r_floor + FW'(1) : r_floor - FW'(1);
                        end else begin
                            r_step <= r_step + SW'(1);
                        end
                    end
                end
                ST_DOOR: begin
                    // Holding pins the countdown at zero; release restarts it.
                    if (w_hold) begin
                        r_step <= '0;
                    end else if (w_tick) begin
                        if (r_step == SW'(DOOR_TICKS - 1)) begin
                            r_step  <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_step <= r_step + SW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_step  <= '0;
                end
            endcase
        end
    end

    a_floor_bounds: assert property (@(posedge clk100m) disable iff (!rst_n)
        w_step_done |-> (r_dir ? (r_floor != TOP) : (r_floor != '0)));

    a_move_door_excl: assert property (@(posedge clk100m) disable iff (!rst_n)
        !(moving && door_open));

    assign cur_floor    = r_floor;
    assign dir_up       = r_dir;
    assign moving       = (r_state == ST_MOVE);
    assign door_open    = (r_state == ST_DOOR);
    assign arrive_pulse = r_arrive;
    assign pending      = r_pending;

endmodule
